// File: rtl/axis_frame_capture_if.sv
// AXI4-Stream video beat bundle: pixel data, valid/ready handshake and framing flags.
// The master drives the payload and the slave answers with tready.
interface axis_frame_capture_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_capture.sv
// AXI4-Stream video sink: captures one frame into RAM, checks SOF/EOF framing,
// sums the stored pixels and can throttle the stream with a rotating ready mask.
module axis_frame_capture #(
    parameter int          WIDTH         = 128,
    parameter int          HEIGHT        = 100,
    parameter int          DATA_WIDTH    = 24,
    parameter logic [15:0] READY_PATTERN = 16'hFFFF,
    parameter int          ADDR_WIDTH    = $clog2(WIDTH * HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_frame_capture_if.slave   s_axis,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_sof,
    output logic                  err_eof,
    output logic [ADDR_WIDTH:0]   pixel_count,
    output logic [15:0]           drop_count,
    output logic [31:0]           checksum
);

    localparam int N     = WIDTH * HEIGHT;
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    state_t                state;
    logic [15:0]           ready_mask;
    logic                  active;
    logic                  accept;
    logic                  last_beat;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           beat_value;
    logic [DATA_WIDTH-1:0] mem [N];

    // tready is decoded straight from registered state so an async reset drops it at once.
    assign active        = (state == WAIT_SOF) || (state == CAPTURE);
    assign s_axis.tready = active & ready_mask[0];
    assign accept        = s_axis.tvalid & s_axis.tready;
    assign busy          = active;
    assign done          = (state == DONE);
    assign beat_value    = 32'(s_axis.tdata);
    assign last_beat     = (pixel_count == CNT_W'(N - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_en   = 1'b0;
        wr_addr = pixel_count[ADDR_WIDTH-1:0];
        if (accept && !arm) begin
            if (s_axis.tuser) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (state == CAPTURE) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ready_mask  <= READY_PATTERN;
            err_sof     <= 1'b0;
            err_eof     <= 1'b0;
            pixel_count <= '0;
            drop_count  <= '0;
            checksum    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (active) ready_mask <= {ready_mask[0], ready_mask[15:1]};

            if (arm) begin
                state       <= WAIT_SOF;
                err_sof     <= 1'b0;
                err_eof     <= 1'b0;
                pixel_count <= '0;
                drop_count  <= '0;
                checksum    <= '0;
            end else if (accept) begin
                if (s_axis.tuser) begin
                    // A SOF always (re)starts the frame; mid-frame it also flags err_sof and masks tlast.
                    pixel_count <= CNT_W'(1);
                    checksum    <= beat_value;
                    if (state == CAPTURE) begin
                        err_sof <= 1'b1;
                    end else if (s_axis.tlast) begin
                        err_eof <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= CAPTURE;
                    end
                end else if (state == WAIT_SOF) begin
                    if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                end else begin
                    pixel_count <= pixel_count + CNT_W'(1);
                    checksum    <= checksum + beat_value;
                    if (last_beat) begin
                        state <= DONE;
                        if (!s_axis.tlast) err_eof <= 1'b1;
                    end else if (s_axis.tlast) begin
                        err_eof <= 1'b1;
                        state   <= DONE;
                    end
                end
            end
        end
    end

    // NOTE: the capture RAM has no reset; clearing it would defeat block-RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= s_axis.tdata;
    end

    // Read-first: a same-address write in this cycle is seen only on the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

endmodule
